hazard_unit: RTL

Pipeline hazard controller for the five-stage RV32 core. It drives the stall and clear inputs of the F/D, D/E and E/M pipeline registers, and it drives the forwarding selects for the E-stage operand muxes. It detects load-use hazards and taken-branch redirects. It sequences multi-cycle multiply stalls with a down-counter FSM. The block sits beside the datapath and samples register indices from the D, E, M and W stages.

---
 rtl/hazard_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32 pipeline hazard controller: forwarding, load-use, branch flush, multiply stall
// Optional HAZARD_PERF_EN adds saturating load-stall and flush event counters.
module hazard_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MulStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
`ifdef HAZARD_PERF_EN
    output logic [15:0] LoadStallCnt,
    output logic [15:0] FlushCnt,
`endif
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 2);

    logic [0:0] state;
    logic [0:0] next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;
    logic       lw_stall;
    logic       lw_resp;
    logic       br_resp;

    // M-stage result is younger than W, so it wins when both match.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        lw_resp    = 1'b0;
        br_resp    = 1'b0;
        next_state = state;
        next_cnt   = cnt;
        if (state == RUN) begin
            if (PCSrcE) begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                br_resp = 1'b1;
            end else if (lw_stall) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
                lw_resp = 1'b1;
            end else if (MulStartE) begin
                StallF     = 1'b1;
                StallD     = 1'b1;
                StallE     = 1'b1;
                FlushM     = 1'b1;
                next_state = BUSY;
                next_cnt   = CNT_LOAD;
            end
        end else begin
            // E is frozen on the multiply, so its redirect/load flags are stale.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            if (cnt == 4'd0)
                next_state = RUN;
            else
                next_cnt = cnt - 4'd1;
        end
        if (!reset) begin
            StallF  = 1'b0;
            StallD  = 1'b0;
            StallE  = 1'b0;
            FlushD  = 1'b0;
            FlushE  = 1'b0;
            FlushM  = 1'b0;
            lw_resp = 1'b0;
            br_resp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            LoadStallCnt <= 16'd0;
            FlushCnt     <= 16'd0;
        end else begin
            if (lw_resp && LoadStallCnt != 16'hFFFF)
                LoadStallCnt <= LoadStallCnt + 16'd1;
            if (br_resp && FlushCnt != 16'hFFFF)
                FlushCnt <= FlushCnt + 16'd1;
        end
    end
`endif

endmodule
